// File: rtl/alu_rr_arbiter_if.sv
// Client and ALU-side signal bundle for alu_rr_arbiter.
// slave = arbiter view, master = clients plus ALU view.
interface alu_rr_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             REQ0;
  logic [3:0]       OP0;
  logic [WIDTH-1:0] A0;
  logic [WIDTH-1:0] B0;
  logic             ACK0;
  logic             DONE0;

  logic             REQ1;
  logic [3:0]       OP1;
  logic [WIDTH-1:0] A1;
  logic [WIDTH-1:0] B1;
  logic             ACK1;
  logic             DONE1;

  logic [WIDTH-1:0] RES;
  logic [5:0]       FLAGS;
  logic             BUSY;

  logic [WIDTH-1:0] ALU_A;
  logic [WIDTH-1:0] ALU_B;
  logic [3:0]       ALU_S;
  logic [WIDTH-1:0] ALU_F;
  logic             ALU_EQ;
  logic             ALU_GT;
  logic             ALU_LT;
  logic             ALU_Z;
  logic             ALU_C;
  logic             ALU_V;

  modport slave (
    input  REQ0, OP0, A0, B0,
    input  REQ1, OP1, A1, B1,
    output ACK0, DONE0, ACK1, DONE1,
    output RES, FLAGS, BUSY,
    output ALU_A, ALU_B, ALU_S,
    input  ALU_F,
    input  ALU_EQ, ALU_GT, ALU_LT,
    input  ALU_Z, ALU_C, ALU_V
  );

  modport master (
    output REQ0, OP0, A0, B0,
    output REQ1, OP1, A1, B1,
    input  ACK0, DONE0, ACK1, DONE1,
    input  RES, FLAGS, BUSY,
    input  ALU_A, ALU_B, ALU_S,
    output ALU_F,
    output ALU_EQ, ALU_GT, ALU_LT,
    output ALU_Z, ALU_C, ALU_V
  );
endinterface

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters.
// Grants, waits LAT cycles for F, then returns F and flags with DONE.
module alu_rr_arbiter #(
  parameter int WIDTH = 8,
  parameter int LAT   = 1
) (
  input logic           CLK,
  input logic           RST,
  alu_rr_arbiter_if.slave bus
);

  typedef enum logic {
    IDLE,
    EXEC
  } state_t;

  localparam logic [2:0] LAT_C = 3'(LAT);

  state_t     state;
  logic [2:0] cnt;
  logic       last;
  logic       win;
  logic       gnt0;
  logic       gnt1;

  // On a tie the requester that did not win last time goes first.
  assign gnt0 = bus.REQ0 & (~bus.REQ1 | last);
  assign gnt1 = bus.REQ1 & (~bus.REQ0 | ~last);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= '0;
      last      <= 1'b1;
      win       <= 1'b0;
      bus.ACK0  <= 1'b0;
      bus.ACK1  <= 1'b0;
      bus.DONE0 <= 1'b0;
      bus.DONE1 <= 1'b0;
      bus.RES   <= '0;
      bus.FLAGS <= '0;
      bus.ALU_A <= '0;
      bus.ALU_B <= '0;
      bus.ALU_S <= '0;
      bus.BUSY  <= 1'b0;
    end else begin
      bus.ACK0  <= 1'b0;
      bus.ACK1  <= 1'b0;
      bus.DONE0 <= 1'b0;
      bus.DONE1 <= 1'b0;
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            gnt0: begin
              bus.ALU_A <= bus.A0;
              bus.ALU_B <= bus.B0;
              bus.ALU_S <= bus.OP0;
              bus.ACK0  <= 1'b1;
              bus.BUSY  <= 1'b1;
              last      <= 1'b0;
              win       <= 1'b0;
              cnt       <= LAT_C;
              state     <= EXEC;
            end
            gnt1: begin
              bus.ALU_A <= bus.A1;
              bus.ALU_B <= bus.B1;
              bus.ALU_S <= bus.OP1;
              bus.ACK1  <= 1'b1;
              bus.BUSY  <= 1'b1;
              last      <= 1'b1;
              win       <= 1'b1;
              cnt       <= LAT_C;
              state     <= EXEC;
            end
            default: ;
          endcase
        end
        EXEC: begin
          if (cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
          end else begin
            bus.RES   <= bus.ALU_F;
            bus.FLAGS <= {bus.ALU_EQ, bus.ALU_GT,
                          bus.ALU_LT, bus.ALU_Z,
                          bus.ALU_C, bus.ALU_V};
            bus.DONE0 <= ~win;
            bus.DONE1 <= win;
            bus.BUSY  <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_ack_mutex: assert property (
    @(posedge CLK) !(bus.ACK0 && bus.ACK1));
  a_done_mutex: assert property (
    @(posedge CLK) !(bus.DONE0 && bus.DONE1));

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Scoreboard bench for alu_rr_arbiter with LAT=1 and LAT=0 builds.
// Bench ALU stubs: registered (LAT=1) and combinational (LAT=0).
module tb_alu_rr_arbiter;

  logic CLK = 1'b0;
  logic RST;
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   n_ack = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  alu_rr_arbiter_if #(.WIDTH(8)) bus1 ();
  alu_rr_arbiter_if #(.WIDTH(8)) bus0 ();

  alu_rr_arbiter #(.WIDTH(8), .LAT(1)) dut1 (
    .CLK(CLK), .RST(RST), .bus(bus1.slave));
  alu_rr_arbiter #(.WIDTH(8), .LAT(0)) dut0 (
    .CLK(CLK), .RST(RST), .bus(bus0.slave));

  // Returns {EQ,GT,LT,Z,C,V, F[7:0]}
  function automatic logic [13:0] alu_model(
    input logic [3:0] s, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] t;
    logic [7:0] f;
    logic c, v;
    case (s)
      4'd1: begin
        t = {1'b0, a} + {1'b0, b};
        f = t[7:0]; c = t[8];
        v = (a[7] == b[7]) && (f[7] != a[7]);
      end
      4'd2: begin
        f = a - b; c = (a < b);
        v = (a[7] != b[7]) && (f[7] != a[7]);
      end
      default: begin
        f = a ^ b; c = 1'b0; v = 1'b0;
      end
    endcase
    return {(a == b), (a > b), (a < b), (f == 8'd0), c, v, f};
  endfunction

  logic [13:0] stub1_q;
  logic [13:0] stub0_c;
  always @(posedge CLK)
    stub1_q <= alu_model(bus1.ALU_S, bus1.ALU_A, bus1.ALU_B);
  assign stub0_c = alu_model(bus0.ALU_S, bus0.ALU_A, bus0.ALU_B);

  assign bus1.ALU_F = stub1_q[7:0];
  assign {bus1.ALU_EQ, bus1.ALU_GT, bus1.ALU_LT,
          bus1.ALU_Z, bus1.ALU_C, bus1.ALU_V} = stub1_q[13:8];
  assign bus0.ALU_F = stub0_c[7:0];
  assign {bus0.ALU_EQ, bus0.ALU_GT, bus0.ALU_LT,
          bus0.ALU_Z, bus0.ALU_C, bus0.ALU_V} = stub0_c[13:8];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               tag, got, exp, $time);
    end
  endtask

  // Operands as driven per port; expected grant order; expected results
  logic [3:0]  snap_op[2];
  logic [7:0]  snap_a[2];
  logic [7:0]  snap_b[2];
  int          gq[$];
  logic [14:0] sb[$];
  int          mp;
  logic [13:0] mr;
  logic [14:0] me;

  always @(negedge CLK) begin
    if (bus1.ACK0 || bus1.ACK1) begin
      mp = bus1.ACK1 ? 1 : 0;
      n_ack++;
      check("ack_mutex", 32'(bus1.ACK0 & bus1.ACK1), 32'd0);
      if (gq.size() == 0) check("unexpected_ack", mp, 99);
      else check("grant_order", mp, gq.pop_front());
      check("alu_a", 32'(bus1.ALU_A), 32'(snap_a[mp]));
      check("alu_b", 32'(bus1.ALU_B), 32'(snap_b[mp]));
      check("alu_s", 32'(bus1.ALU_S), 32'(snap_op[mp]));
      mr = alu_model(snap_op[mp], snap_a[mp], snap_b[mp]);
      sb.push_back({mp[0], mr});
    end
    if (bus1.DONE0 || bus1.DONE1) begin
      check("done_mutex", 32'(bus1.DONE0 & bus1.DONE1), 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(bus1.DONE1), 32'd99);
      end else begin
        me = sb.pop_front();
        check("done_port", 32'(bus1.DONE1), 32'(me[14]));
        check("res", 32'(bus1.RES), 32'(me[7:0]));
        check("flags", 32'(bus1.FLAGS), 32'(me[13:8]));
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic req(input int p, input logic [3:0] op,
                     input logic [7:0] a, input logic [7:0] b);
    snap_op[p] = op; snap_a[p] = a; snap_b[p] = b;
    if (p == 0) begin
      bus1.OP0 = op; bus1.A0 = a; bus1.B0 = b; bus1.REQ0 = 1'b1;
    end else begin
      bus1.OP1 = op; bus1.A1 = a; bus1.B1 = b; bus1.REQ1 = 1'b1;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((bus1.BUSY || sb.size() != 0) && n < 50) begin
      tick();
      n++;
    end
    check(tag, 32'(n < 50), 32'd1);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  initial begin
    int acks, last_c, n, base;
    logic [13:0] e0;
    RST = 1'b1;
    bus1.REQ0 = 0; bus1.OP0 = 0; bus1.A0 = 0; bus1.B0 = 0;
    bus1.REQ1 = 0; bus1.OP1 = 0; bus1.A1 = 0; bus1.B1 = 0;
    bus0.REQ0 = 0; bus0.OP0 = 0; bus0.A0 = 0; bus0.B0 = 0;
    bus0.REQ1 = 0; bus0.OP1 = 0; bus0.A1 = 0; bus0.B1 = 0;

    // Reset held 2 cycles with REQ0 high
    req(0, 4'd1, 8'h01, 8'h02);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_outs", {bus1.ACK0, bus1.ACK1, bus1.DONE0, bus1.DONE1,
                         bus1.BUSY, bus1.ALU_S, bus1.FLAGS}, 32'd0);
      check("rst_data", {bus1.RES, bus1.ALU_A, bus1.ALU_B}, 32'd0);
    end
    gq.push_back(0);
    RST = 1'b0;
    tick();
    check("first_ack0", 32'(bus1.ACK0), 32'd1);
    bus1.REQ0 = 1'b0;
    wait_idle("idle_after_reset");

    // Single op, operands changed after ACK
    req(0, 4'd1, 8'h0F, 8'h05);
    gq.push_back(0);
    tick();
    check("single_ack0", 32'(bus1.ACK0), 32'd1);
    check("single_alu_a", 32'(bus1.ALU_A), 32'h0F);
    check("single_alu_b", 32'(bus1.ALU_B), 32'h05);
    check("single_alu_s", 32'(bus1.ALU_S), 32'h1);
    check("single_busy", 32'(bus1.BUSY), 32'd1);
    bus1.REQ0 = 1'b0; bus1.A0 = 8'hFF;
    tick();
    check("single_no_done_yet", 32'(bus1.DONE0), 32'd0);
    tick();
    check("single_done0", 32'(bus1.DONE0), 32'd1);
    check("single_done1", 32'(bus1.DONE1), 32'd0);
    check("single_res", 32'(bus1.RES), 32'h14);
    check("single_flags", 32'(bus1.FLAGS), 32'b010000);
    tick();
    check("single_done_pulse", 32'(bus1.DONE0), 32'd0);
    check("single_busy_off", 32'(bus1.BUSY), 32'd0);
    wait_idle("idle_single");

    // Tie with both held: grants alternate, 3 cycles apart
    do_reset();
    gq.push_back(0); gq.push_back(1); gq.push_back(0); gq.push_back(1);
    req(0, 4'd1, 8'h0C, 8'h03);
    req(1, 4'd2, 8'h30, 8'h05);
    acks = 0; last_c = 0; n = 0;
    while (acks < 4 && n < 40) begin
      tick();
      n++;
      if (bus1.ACK0 || bus1.ACK1) begin
        if (acks > 0) check("tie_gap", cyc - last_c, 3);
        last_c = cyc;
        acks++;
        if (acks == 4) begin
          bus1.REQ0 = 1'b0; bus1.REQ1 = 1'b0;
        end
      end
    end
    check("tie_acks", acks, 4);
    bus1.REQ0 = 1'b0; bus1.REQ1 = 1'b0;
    wait_idle("idle_tie");

    // Request during EXEC waits; request dropped before grant is lost
    base = n_ack;
    req(0, 4'd1, 8'h80, 8'h80);
    gq.push_back(0);
    tick();
    check("exec_ack0", 32'(bus1.ACK0), 32'd1);
    bus1.REQ0 = 1'b0;
    tick();
    req(1, 4'd3, 8'h07, 8'h09);
    gq.push_back(1);
    tick();
    check("exec_done0", 32'(bus1.DONE0), 32'd1);
    check("exec_no_ack1_yet", 32'(bus1.ACK1), 32'd0);
    tick();
    check("exec_ack1", 32'(bus1.ACK1), 32'd1);
    bus1.REQ1 = 1'b0;
    req(0, 4'd1, 8'h11, 8'h22);
    tick();
    bus1.REQ0 = 1'b0;
    wait_idle("idle_exec");
    repeat (4) tick();
    check("dropped_req_no_ack", n_ack - base, 2);

    // LAT=0 build: DONE one cycle after ACK
    bus0.OP0 = 4'd2; bus0.A0 = 8'h25; bus0.B0 = 8'h10;
    bus0.REQ0 = 1'b1;
    e0 = alu_model(4'd2, 8'h25, 8'h10);
    tick();
    check("lat0_ack0", 32'(bus0.ACK0), 32'd1);
    bus0.REQ0 = 1'b0;
    tick();
    check("lat0_done0", 32'(bus0.DONE0), 32'd1);
    check("lat0_res", 32'(bus0.RES), 32'(e0[7:0]));
    check("lat0_flags", 32'(bus0.FLAGS), 32'(e0[13:8]));
    check("lat0_res_const", 32'(bus0.RES), 32'h15);

    // Reset mid-op aborts and re-arbitrates from LAST=1
    req(0, 4'd1, 8'h0C, 8'h03);
    req(1, 4'd2, 8'h30, 8'h05);
    gq.push_back(0);
    tick();
    check("mid_ack0", 32'(bus1.ACK0), 32'd1);
    check("mid_busy", 32'(bus1.BUSY), 32'd1);
    RST = 1'b1;
    tick();
    check("mid_res", 32'(bus1.RES), 32'd0);
    check("mid_flags", 32'(bus1.FLAGS), 32'd0);
    check("mid_busy_off", 32'(bus1.BUSY), 32'd0);
    check("mid_no_done", 32'({bus1.DONE0, bus1.DONE1}), 32'd0);
    sb.delete();
    gq.delete();
    gq.push_back(0);
    RST = 1'b0;
    tick();
    check("mid_regrant0", 32'(bus1.ACK0), 32'd1);
    check("mid_no_stale_done", 32'(bus1.DONE0), 32'd0);
    bus1.REQ0 = 1'b0; bus1.REQ1 = 1'b0;
    wait_idle("idle_mid");

    check("grants_consumed", gq.size(), 0);
    check("results_consumed", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
